// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: cascaded BCD up-counter with run/pause/done control, preset load and terminal limit
module bcd_timer_ctrl #(
  parameter int DIGITS      = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] limit,
  output logic [4*DIGITS-1:0] q,
  output logic [1:0]          state,
  output logic                done,
  output logic                carry,
  output logic                load_err
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t st, st_n;
  logic [W-1:0] q_n, inc;
  logic all9, lim_ok, ld_ok, term, done_n, carry_n, lerr_n;
  // all9 ripples up the digits: a digit steps only when every lower digit is 9
  always_comb begin
    inc = q;
    all9 = 1'b1;
    lim_ok = 1'b1;
    ld_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = all9 ? (q[4*i+:4] == 4'd9 ? 4'd0 : q[4*i+:4] + 4'd1) : q[4*i+:4];
      all9 = all9 && q[4*i+:4] == 4'd9;
      lim_ok = lim_ok && limit[4*i+:4] <= 4'd9;
      ld_ok = ld_ok && load_val[4*i+:4] <= 4'd9;
    end
  end
  assign term = tick && lim_ok && q == limit;
  always_comb begin
    st_n = st;
    q_n = q;
    done_n = 1'b0;
    carry_n = 1'b0;
    lerr_n = 1'b0;
    if (clear) begin
      st_n = IDLE;
      q_n = '0;
    end else if (load && (st == IDLE || st == PAUSE)) begin
      q_n = ld_ok ? load_val : q;
      lerr_n = !ld_ok;
    end else if (st == RUN) begin
      st_n = pause ? PAUSE : RUN;
      if (term && !AUTO_RELOAD) begin
        st_n = DONE;
        done_n = 1'b1;
      end else if (tick) begin
        q_n = term ? '0 : inc;
        carry_n = all9;
        done_n = term;
      end
    end else if (start) begin
      st_n = RUN;
      q_n = st == DONE ? '0 : q;
    end else done_n = st == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      q <= '0;
      done <= 1'b0;
      carry <= 1'b0;
      load_err <= 1'b0;
    end else begin
      st <= st_n;
      q <= q_n;
      done <= done_n;
      carry <= carry_n;
      load_err <= lerr_n;
    end
  end
  assign state = st;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: scoreboard bench running stop-at-limit and auto-reload instances against an integer model
module tb_bcd_timer_ctrl;
  typedef struct packed {
    logic [11:0] q;
    logic [1:0]  st;
    logic        done;
    logic        carry;
    logic        lerr;
  } obs_t;
  logic clk = 1'b0;
  logic reset, tick, start, pause, clear, load;
  logic [11:0] load_val, limit;
  logic [11:0] q0, q1;
  logic [1:0] st0, st1;
  logic done0, done1, carry0, carry1, lerr0, lerr1;
  int checks = 0, errors = 0;
  int mq[2], mst[2];
  obs_t exp0[$], exp1[$];
  always #5 clk = ~clk;
  bcd_timer_ctrl #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause), .clear(clear),
    .load(load), .load_val(load_val), .limit(limit), .q(q0), .state(st0), .done(done0),
    .carry(carry0), .load_err(lerr0));
  bcd_timer_ctrl #(.DIGITS(3), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause), .clear(clear),
    .load(load), .load_val(load_val), .limit(limit), .q(q1), .state(st1), .done(done1),
    .carry(carry1), .load_err(lerr1));
  function automatic int dec(logic [11:0] v);
    int r, d;
    r = 0;
    for (int i = 2; i >= 0; i--) begin
      d = int'(v[4*i+:4]);
      if (d > 9) return -1;
      r = r * 10 + d;
    end
    return r;
  endfunction
  function automatic logic [11:0] enc(int v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // states: 0 idle, 1 run, 2 pause, 3 done; q kept as a plain integer
  task automatic mstep(int k, bit ar);
    obs_t e;
    int lim;
    bit pulse, cy, le;
    pulse = 0;
    cy = 0;
    le = 0;
    lim = dec(limit);
    if (reset || clear) begin
      mq[k] = 0;
      mst[k] = 0;
    end else if (load && (mst[k] == 0 || mst[k] == 2)) begin
      if (dec(load_val) >= 0) mq[k] = dec(load_val);
      else le = 1;
    end else if (mst[k] == 1) begin
      if (tick && mq[k] == lim) begin
        pulse = 1;
        if (!ar) mst[k] = 3;
        else begin
          cy = mq[k] == 999;
          mq[k] = 0;
          mst[k] = pause ? 2 : 1;
        end
      end else begin
        if (tick) begin
          cy = mq[k] == 999;
          mq[k] = (mq[k] + 1) % 1000;
        end
        if (pause) mst[k] = 2;
      end
    end else if (start) begin
      if (mst[k] == 3) mq[k] = 0;
      mst[k] = 1;
    end
    e.q = enc(mq[k]);
    e.st = 2'(mst[k]);
    e.done = mst[k] == 3 || (pulse && ar);
    e.carry = cy;
    e.lerr = le;
    if (k == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    mstep(0, 1'b0);
    mstep(1, 1'b1);
    #1;
  endtask
  task automatic idle_in();
    {reset, tick, start, pause, clear, load} = '0;
  endtask
  task automatic cmp(string n, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got q=%h st=%b done=%b carry=%b lerr=%b, expected q=%h st=%b done=%b carry=%b lerr=%b",
               n, a.q, a.st, a.done, a.carry, a.lerr, e.q, e.st, e.done, e.carry, e.lerr);
    end
  endtask
  always @(negedge clk) begin
    if (exp0.size() > 0) cmp("stop_at_limit", {q0, st0, done0, carry0, lerr0}, exp0.pop_front());
    if (exp1.size() > 0) cmp("auto_reload", {q1, st1, done1, carry1, lerr1}, exp1.pop_front());
  end
  initial begin
    idle_in();
    load_val = '0;
    limit = 12'h999;
    reset = 1'b1;
    repeat (2) cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (20) cyc();
    idle_in();
    clear = 1'b1;
    cyc();
    idle_in();
    load = 1'b1;
    load_val = 12'h995;
    limit = 12'h003;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (12) cyc();
    idle_in();
    clear = 1'b1;
    limit = 12'h025;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (30) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    idle_in();
    clear = 1'b1;
    limit = 12'h003;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (10) cyc();
    idle_in();
    clear = 1'b1;
    cyc();
    idle_in();
    load = 1'b1;
    load_val = 12'h042;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    pause = 1'b1;
    cyc();
    idle_in();
    load = 1'b1;
    load_val = 12'h1A5;
    cyc();
    load_val = 12'h199;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (3) cyc();
    {clear, load, start} = 3'b111;
    cyc();
    idle_in();
    load = 1'b1;
    load_val = 12'h004;
    limit = 12'h005;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    cyc();
    pause = 1'b1;
    cyc();
    idle_in();
    clear = 1'b1;
    limit = 12'h999;
    cyc();
    idle_in();
    load = 1'b1;
    load_val = 12'h517;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    tick = 1'b1;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    repeat (3000) begin
      reset = $urandom_range(0, 199) == 0;
      tick = $urandom_range(0, 9) < 7;
      start = $urandom_range(0, 9) == 0;
      pause = $urandom_range(0, 19) == 0;
      clear = $urandom_range(0, 49) == 0;
      load = $urandom_range(0, 19) == 0;
      load_val = $urandom_range(0, 3) == 0 ? 12'($urandom) : enc(int'($urandom_range(0, 999)));
      if ($urandom_range(0, 99) == 0)
        case ($urandom_range(0, 3))
          0: limit = 12'($urandom);
          1: limit = 12'h999;
          default: limit = enc(int'($urandom_range(0, 40)));
        endcase
      cyc();
    end
    idle_in();
    repeat (2) @(negedge clk);
    checks++;
    if (exp0.size() + exp1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp0.size() + exp1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 3: number of cascaded BCD digits, q digit 0 least significant.
REQ-002 The block SHALL provide parameter AUTO_RELOAD, default 0: 0 = stop at limit, 1 = restart from 0 at limit.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  count enable pulse, one count per cycle high.
REQ-006 start  in  1  start/resume request.
REQ-007 pause  in  1  pause request.
REQ-008 clear  in  1  zero counter, return to IDLE.
REQ-009 load  in  1  preset request.
REQ-010 load_val  in  4*DIGITS  preset value, packed BCD.
REQ-011 limit  in  4*DIGITS  terminal value, packed BCD, sampled every cycle.
REQ-012 q  out  4*DIGITS  current count, packed BCD, registered.
REQ-013 state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 done  out  1  terminal indication, registered.
REQ-015 carry  out  1  one-cycle pulse on all-9s rollover to 0.
REQ-016 load_err  out  1  one-cycle pulse on rejected load.

Function
REQ-017 Counting SHALL occur only when state=RUN and tick=1; new q visible the cycle after the tick edge (latency 1).
REQ-018 Each count SHALL increment digit 0; digit i>0 SHALL increment only when all lower digits are 9; any digit at 9 that increments SHALL become 0.
REQ-019 A count from all-9s (999 for DIGITS=3) SHALL yield all-0s and pulse carry for exactly one cycle.
REQ-020 Terminal tick = tick=1 in RUN with q==limit; limit with any digit >9 SHALL never match.
REQ-021 Terminal tick, AUTO_RELOAD=0: q SHALL hold at limit, state->DONE, done held 1 while in DONE.
REQ-022 Terminal tick, AUTO_RELOAD=1: q<=0, done pulses 1 cycle, state stays RUN.
REQ-023 Loaded q above limit SHALL count up through all-9s rollover (carry pulse) before reaching limit.
REQ-024 Transitions: IDLE-start->RUN; RUN-pause->PAUSE; PAUSE-start->RUN; DONE-start->RUN with q<=0 and done<=0.
REQ-025 Per-cycle priority SHALL be clear > load > pause > start; lower-priority requests in the same cycle ignored.
REQ-026 clear in any state: q<=0, state<=IDLE, done<=0, no carry/done pulse.
REQ-027 load SHALL be accepted only in IDLE or PAUSE; accepted: q<=load_val, state unchanged.
REQ-028 load with any load_val digit >9 SHALL leave q unchanged and pulse load_err one cycle; load in RUN/DONE ignored, no load_err.
REQ-029 Terminal tick and pause same cycle in RUN: count/terminal action SHALL apply; AUTO_RELOAD=0 -> DONE; AUTO_RELOAD=1 -> PAUSE.
REQ-030 pause and start in states other than RUN/PAUSE/DONE as listed SHALL be ignored; start in RUN ignored.
REQ-031 q SHALL never hold a non-BCD digit.

Reset
REQ-032 reset=1 at a clk edge SHALL force q=0, state=IDLE, done=0, carry=0, load_err=0, overriding all inputs.
REQ-033 reset asserted mid-RUN SHALL abandon the count with no carry/done pulse; counting resumes only after a new start.
REQ-034 Outputs SHALL be defined (all 0) from the first edge with reset=1.

Verification
REQ-035 Reset, start, tick every cycle, limit=999: q 000->001->...->009->010; after 999 q=000 with carry=1 one cycle.
REQ-036 AUTO_RELOAD=0, limit=025, run from 0: q stops at 025, state=11, done=1 held; further ticks no change; start -> q=000, RUN.
REQ-037 AUTO_RELOAD=1, limit=003, continuous ticks: q 0,1,2,3,0,1,..., done pulses each 3->0 transition.
REQ-038 PAUSE at q=042, load 0x1A5 -> load_err=1, q=042; load 0x199 -> q=199; start resumes from 199.
REQ-039 Same cycle clear+load+start in RUN -> q=000, IDLE; pause+terminal tick (AUTO_RELOAD=0) -> DONE.
REQ-040 reset pulsed at q=517 in RUN -> next cycle q=000, IDLE, no carry/done; ticks without start leave q=000.
